// File: rtl/aes_256_inv.sv
// Iterative AES-256 inverse cipher: expands the key schedule on chip, then runs one inverse round per clock.
// Optional build macro AES_256_INV_KEY_CACHE_EN skips expansion when the key equals the last expanded key.
module aes_256_inv #(
    parameter int unsigned NR  = 14,
    parameter int unsigned NRK = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);
    localparam int unsigned BW = 128;
    localparam int unsigned KW = 256;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] EXP_LAST  = CW'(13);
    localparam logic [CW-1:0] RND_FIRST = CW'(NR - 1);

    if (NR != 14 || NRK != NR + 1) begin : g_param_check
        $error("aes_256_inv: NR must be 14 and NRK must be 15");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_DONE} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Row r of column c is taken from column c-r, then inverse S-box, key add, optional mix
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [127:0] t;
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                t[127-8*(4*c+rr) -: 8] = inv_sbox(s[127-8*(4*((c-rr+4)%4)+rr) -: 8]);
            end
        end
        t = t ^ k;
        r = t;
        if (mix) begin
            for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
        end
        return r;
    endfunction

    // Next four schedule words from the two previous round keys; odd steps apply RotWord and Rcon
    function automatic logic [127:0] expand_step(input logic [127:0] prev2, input logic [127:0] prev1,
                                                 input logic [CW-1:0] i);
        logic [31:0] t, w0, w1, w2, w3;
        logic [7:0]  rcon;
        rcon = 8'h01 << ((i - CW'(1)) >> 1);
        if (i[0]) t = sub_word({prev1[23:0], prev1[31:24]}) ^ {rcon, 24'h000000};
        else      t = sub_word(prev1[31:0]);
        w0 = prev2[127:96] ^ t;
        w1 = prev2[95:64]  ^ w0;
        w2 = prev2[63:32]  ^ w1;
        w3 = prev2[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_e          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] s_q, s_d;
    logic [BW-1:0] ct_q, ct_d;
    logic [BW-1:0] out_q, out_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] rk_q [NRK];
    logic [BW-1:0] rk_d [NRK];
    logic [BW-1:0] exp_word;
    logic [BW-1:0] rnd_word;
    logic          accept;
    logic          key_hit;

    assign accept   = in_valid && in_ready_q;
    assign exp_word = expand_step(rk_q[cnt_q - CW'(1)], rk_q[cnt_q], cnt_q);
    assign rnd_word = inv_round(s_q, rk_q[cnt_q], cnt_q != '0);

`ifdef AES_256_INV_KEY_CACHE_EN
    logic [KW-1:0] ckey_q, ckey_d;
    logic          cache_valid_q, cache_valid_d;

    assign key_hit = cache_valid_q && (key == ckey_q);

    // Cache holds the key whose full schedule currently sits in rk
    always_comb begin
        ckey_d        = ckey_q;
        cache_valid_d = cache_valid_q;
        if (accept && !key_hit) cache_valid_d = 1'b0;
        if (fsm_q == S_EXPAND && cnt_q == EXP_LAST) begin
            ckey_d        = {rk_q[0], rk_q[1]};
            cache_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cache_valid_q <= 1'b0;
        else     cache_valid_q <= cache_valid_d;
    end

    always_ff @(posedge clk) begin
        ckey_q <= ckey_d;
    end
`else
    assign key_hit = 1'b0;
`endif

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        ct_d        = ct_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rk_d        = rk_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    ct_d    = state;
                    rk_d[0] = key[255:128];
                    rk_d[1] = key[127:0];
                    if (key_hit) begin
                        fsm_d = S_ROUND;
                        cnt_d = RND_FIRST;
                        s_d   = state ^ rk_q[NRK-1];
                    end else begin
                        fsm_d = S_EXPAND;
                        cnt_d = CW'(1);
                    end
                end
            end
            S_EXPAND: begin
                rk_d[cnt_q + CW'(1)] = exp_word;
                if (cnt_q == EXP_LAST) begin
                    fsm_d = S_ROUND;
                    cnt_d = RND_FIRST;
                    s_d   = ct_q ^ exp_word;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ROUND: begin
                s_d = rnd_word;
                if (cnt_q == '0) begin
                    fsm_d       = S_DONE;
                    out_d       = rnd_word;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d       = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
        in_ready_d = (fsm_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded before use
    always_ff @(posedge clk) begin
        s_q  <= s_d;
        ct_q <= ct_d;
        rk_q <= rk_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule
